// File: rtl/pc_src_ctrl_mux_pkg.sv
// -----------------------------------------------------------------------------
// pc_src_pkg
// Shared definitions for the next-PC source selection path. The control unit
// imports this package too, so both sides agree on the select encoding.
//   PCSRC_*          : next-PC source select codes
//   PC_RESET_DEFAULT : default reset value of the program counter
// -----------------------------------------------------------------------------
package pc_src_pkg;

    localparam logic [1:0] PCSRC_EXC  = 2'd0;
    localparam logic [1:0] PCSRC_EPC  = 2'd1;
    localparam logic [1:0] PCSRC_ALU  = 2'd2;
    localparam logic [1:0] PCSRC_SHL2 = 2'd3;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_src_ctrl_mux_sel.sv
// -----------------------------------------------------------------------------
// pc_src_sel
// Combinational 4:1 WIDTH-bit selector, usable for any datapath mux that
// follows the pc_src_pkg select encoding.
//   i_sel  : 2-bit select
//   i_exc  : routed out for PCSRC_EXC, and for any unknown select
//   i_epc  : routed out for PCSRC_EPC
//   i_alu  : routed out for PCSRC_ALU
//   i_shl2 : routed out for PCSRC_SHL2
//   o_out  : selected value, unmodified
// -----------------------------------------------------------------------------
module pc_src_sel
    import pc_src_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       i_sel,
    input  logic [WIDTH-1:0] i_exc,
    input  logic [WIDTH-1:0] i_epc,
    input  logic [WIDTH-1:0] i_alu,
    input  logic [WIDTH-1:0] i_shl2,
    output logic [WIDTH-1:0] o_out
);

    // Pure selection with no alignment or masking. The exception vector sits
    // in the default branch, so an X/Z select falls back to it and the
    // output is always assigned (no latch).
    always_comb begin
        o_out = i_exc;
        case (i_sel)
            PCSRC_EPC:  o_out = i_epc;
            PCSRC_ALU:  o_out = i_alu;
            PCSRC_SHL2: o_out = i_shl2;
            default:    o_out = i_exc;
        endcase
    end

endmodule

// File: rtl/pc_src_ctrl_mux.sv
// -----------------------------------------------------------------------------
// pc_src_ctrl_mux
// Next-PC source selector for the multicycle MIPS datapath, together with
// the program counter register it feeds.
//   clk               : system clock, rising edge
//   reset             : synchronous, active-high; loads RESET_PC
//   PCSourceCtrl      : next-PC source select (pc_src_pkg encoding)
//   Exception_Destiny : exception handler address (select 0)
//   EPC_Out           : saved exception PC for rte (select 1)
//   ALU_Out           : ALU result, PC+4 or jr target (select 2)
//   Shift_Left_2      : shifted branch/jump target (select 3)
//   PCWrite           : load enable for the PC register
//   Data_out          : selected next-PC, combinational
//   PC_Out            : registered program counter
//   Misaligned        : Data_out is not word aligned (informational only)
// -----------------------------------------------------------------------------
module pc_src_ctrl_mux
    import pc_src_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = PC_RESET_DEFAULT[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       PCSourceCtrl,
    input  logic [WIDTH-1:0] Exception_Destiny,
    input  logic [WIDTH-1:0] EPC_Out,
    input  logic [WIDTH-1:0] ALU_Out,
    input  logic [WIDTH-1:0] Shift_Left_2,
    input  logic             PCWrite,
    output logic [WIDTH-1:0] Data_out,
    output logic [WIDTH-1:0] PC_Out,
    output logic             Misaligned
);

    logic [WIDTH-1:0] w_nextPc;
    logic [WIDTH-1:0] r_pc;

    pc_src_sel #(
        .WIDTH (WIDTH)
    ) u_sel (
        .i_sel  (PCSourceCtrl),
        .i_exc  (Exception_Destiny),
        .i_epc  (EPC_Out),
        .i_alu  (ALU_Out),
        .i_shl2 (Shift_Left_2),
        .o_out  (w_nextPc)
    );

    // PC register: reset wins over PCWrite; otherwise it loads whatever the
    // selector presents at the edge, or holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (PCWrite) begin
            r_pc <= w_nextPc;
        end
    end

    // The alignment flag only reports; the control unit decides whether a
    // misaligned fetch becomes an exception.
    assign Misaligned = |w_nextPc[1:0];
    assign Data_out   = w_nextPc;
    assign PC_Out     = r_pc;

endmodule

// File: tb/tb_pc_src_ctrl_mux.sv
// -----------------------------------------------------------------------------
// tb_pc_src_ctrl_mux
// Self-checking bench for pc_src_ctrl_mux: directed steps followed by a
// randomized run, all compared against a reference model of the next-PC
// selection and PC register.
// -----------------------------------------------------------------------------
module tb_pc_src_ctrl_mux;
    import pc_src_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [1:0]  PCSourceCtrl;
    logic [31:0] Exception_Destiny;
    logic [31:0] EPC_Out;
    logic [31:0] ALU_Out;
    logic [31:0] Shift_Left_2;
    logic        PCWrite;
    logic [31:0] Data_out;
    logic [31:0] PC_Out;
    logic        Misaligned;

    int          checks;
    int          failures;
    logic [31:0] modelPc;

    pc_src_ctrl_mux #(
        .WIDTH    (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .PCSourceCtrl      (PCSourceCtrl),
        .Exception_Destiny (Exception_Destiny),
        .EPC_Out           (EPC_Out),
        .ALU_Out           (ALU_Out),
        .Shift_Left_2      (Shift_Left_2),
        .PCWrite           (PCWrite),
        .Data_out          (Data_out),
        .PC_Out            (PC_Out),
        .Misaligned        (Misaligned)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference next-PC: the candidate whose index is the select value,
    // with an unknown select treated as the exception vector.
    function automatic logic [31:0] refSelect(input logic [1:0] sel,
                                              input logic [31:0] exc,
                                              input logic [31:0] epc,
                                              input logic [31:0] alu,
                                              input logic [31:0] shl);
        logic [31:0] cand [4];
        cand[0] = exc;
        cand[1] = epc;
        cand[2] = alu;
        cand[3] = shl;
        if ($isunknown(sel)) return exc;
        return cand[sel];
    endfunction

    // Reference PC register, stepped at every rising edge from the inputs
    // the bench is currently driving.
    always @(posedge clk) begin
        if (reset)
            modelPc <= RST_PC;
        else if (PCWrite)
            modelPc <= refSelect(PCSourceCtrl, Exception_Destiny, EPC_Out,
                                 ALU_Out, Shift_Left_2);
    end

    // Drives a new input set half a cycle away from the active edge, then
    // lets the combinational outputs settle and checks them.
    task automatic applyStimulus(input logic [1:0] sel, input logic [31:0] exc,
                                 input logic [31:0] epc, input logic [31:0] alu,
                                 input logic [31:0] shl, input logic wr,
                                 input logic rst, input string tag);
        @(negedge clk);
        PCSourceCtrl      = sel;
        Exception_Destiny = exc;
        EPC_Out           = epc;
        ALU_Out           = alu;
        Shift_Left_2      = shl;
        PCWrite           = wr;
        reset             = rst;
        #2;
        checkOutput(tag);
    endtask

    // Waits for the next rising edge and checks shortly after it.
    task automatic clockEdge(input string tag);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] expData;
        logic        expMis;
        expData = refSelect(PCSourceCtrl, Exception_Destiny, EPC_Out, ALU_Out,
                            Shift_Left_2);
        expMis  = (expData % 4) != 0;

        checks++;
        assert (Data_out === expData) else begin
            failures++;
            $error("[TB] FAIL %s Data_out observed=%h expected=%h", tag, Data_out, expData);
        end
        checks++;
        assert (Misaligned === expMis) else begin
            failures++;
            $error("[TB] FAIL %s Misaligned observed=%b expected=%b", tag, Misaligned, expMis);
        end
        checks++;
        assert (PC_Out === modelPc) else begin
            failures++;
            $error("[TB] FAIL %s PC_Out observed=%h expected=%h", tag, PC_Out, modelPc);
        end
    endtask

    // Directed steps, then a randomized run, then the summary.
    initial begin
        checks   = 0;
        failures = 0;
        reset             = 1'b1;
        PCWrite           = 1'b0;
        PCSourceCtrl      = PCSRC_EXC;
        Exception_Destiny = 32'h0;
        EPC_Out           = 32'h0;
        ALU_Out           = 32'h0;
        Shift_Left_2      = 32'h0;

        // Reset state.
        clockEdge("reset_a");
        clockEdge("reset_b");

        // Select sweep, no writes.
        applyStimulus(PCSRC_EXC,  32'd5, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, "sweep0");
        applyStimulus(PCSRC_EPC,  32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, "sweep1");
        applyStimulus(PCSRC_ALU,  32'd5, 32'd0, 32'd5, 32'd0, 1'b0, 1'b0, "sweep2");
        applyStimulus(PCSRC_SHL2, 32'd0, 32'd0, 32'd0, 32'd5, 1'b0, 1'b0, "sweep3");

        // Isolation with distinct values on every input.
        for (int s = 0; s < 4; s++)
            applyStimulus(2'(s), 32'hA0, 32'hB4, 32'hC8, 32'hDC, 1'b0, 1'b0, "isolate");

        // Reset dominates PCWrite; Data_out keeps following the select.
        applyStimulus(PCSRC_SHL2, 32'h0, 32'h0, 32'h0, 32'h0000_0100, 1'b1, 1'b0, "preload");
        clockEdge("preload_edge");
        applyStimulus(PCSRC_ALU, 32'h0, 32'h0, 32'h40, 32'h0, 1'b1, 1'b1, "rst_wr");
        clockEdge("rst_wr_edge");
        applyStimulus(PCSRC_ALU, 32'h0, 32'h0, 32'h40, 32'h0, 1'b1, 1'b0, "rst_release");
        clockEdge("rst_release_edge");

        // One-cycle write pulse, then hold with a changed input.
        applyStimulus(PCSRC_SHL2, 32'h0, 32'h0, 32'h0, 32'h0040_0100, 1'b1, 1'b0, "wr_pulse");
        clockEdge("wr_pulse_edge");
        applyStimulus(PCSRC_SHL2, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, "wr_hold");
        clockEdge("wr_hold_edge");

        // Misalignment flag, data passes through unchanged.
        applyStimulus(PCSRC_ALU, 32'h0, 32'h0, 32'h0000_0006, 32'h0, 1'b0, 1'b0, "misaligned");
        applyStimulus(PCSRC_ALU, 32'h0, 32'h0, 32'h0000_0008, 32'h0, 1'b0, 1'b0, "aligned");

        // Full-width value through the mux and into the PC.
        applyStimulus(PCSRC_EPC, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 1'b0, "fullwidth");
        clockEdge("fullwidth_edge");

        // Unknown select falls back to the exception vector.
        applyStimulus(2'bxx, 32'h8000_0180, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, "sel_x");

        // Randomized run: random selects, data, back-to-back writes and
        // occasional resets.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                          $urandom, 1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 9) == 0), "random");
            clockEdge("random_edge");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_src_ctrl_mux.md
# pc_src_ctrl_mux

Next-PC source selector for the multicycle MIPS datapath. It picks one of four 32-bit candidate addresses (exception vector, EPC, ALU result, shifted jump/branch target) using the 2-bit `PCSourceCtrl` from the control unit. It drives the selected value combinationally to the PC input, and it also holds a registered copy of the program counter, written under `PCWrite`.

## Interface

Parameters:
- `WIDTH`, default 32: width of the address datapath.
- `RESET_PC`, default 32'h0000_0000: value loaded into `PC_Out` on reset.

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `PCSourceCtrl`  in  2  next-PC source select from the control unit.
- `Exception_Destiny`  in  WIDTH  exception handler address (select 0).
- `EPC_Out`  in  WIDTH  saved exception PC, used on `rte` (select 1).
- `ALU_Out`  in  WIDTH  ALU result, e.g. PC+4 or `jr` target (select 2).
- `Shift_Left_2`  in  WIDTH  shifted branch/jump target (select 3).
- `PCWrite`  in  1  load enable for the internal PC register.
- `Data_out`  out  WIDTH  selected next-PC value, combinational.
- `PC_Out`  out  WIDTH  registered program counter.
- `Misaligned`  out  1  high when `Data_out[1:0] != 2'b00`, combinational.

## Operation

- Select mapping: 0 → `Exception_Destiny`; 1 → `EPC_Out`; 2 → `ALU_Out`; 3 → `Shift_Left_2`.
- `Data_out` is a pure function of `PCSourceCtrl` and the four data inputs. It has no dependence on `clk`, `reset` or `PCWrite`.
- The selected input passes through unmodified. There is no masking, sign extension or alignment.
- When `PCSourceCtrl` is X or Z, the default branch selects `Exception_Destiny`. This keeps synthesis free of latches.
- `Misaligned` is informational only. It does not alter `Data_out` or block the PC write. The control unit decides whether to raise an exception.
- PC register behaviour:
  - `reset`=1 → `PC_Out` ← `RESET_PC`.
  - `reset`=0 and `PCWrite`=1 → `PC_Out` ← `Data_out`.
  - `reset`=0 and `PCWrite`=0 → `PC_Out` holds.

## Timing

- `Data_out` and `Misaligned` have zero-cycle latency. They settle within the same cycle in which inputs change.
- `PC_Out` has a one-cycle latency. It reflects the `Data_out` value sampled at the rising edge where `PCWrite`=1.
- Reset is synchronous:
  - Asserting `reset` between edges does not change `PC_Out` until the next rising edge.
  - `reset` dominates `PCWrite` when both are high.
- `reset` has no effect on the combinational outputs. Immediately after reset, `Data_out` still follows the current select and inputs.
- Changing `PCSourceCtrl` in the same cycle as `PCWrite`=1: the value loaded is the one selected at the edge.
- Back-to-back `PCWrite` cycles load the new selection each cycle. There are no hazards and no internal pipeline.

## Structure

- The shared package `pc_src_pkg` holds:
  - select constants `PCSRC_EXC`=2'd0, `PCSRC_EPC`=2'd1, `PCSRC_ALU`=2'd2, `PCSRC_SHL2`=2'd3;
  - the default `RESET_PC`.
- The control unit imports the same package.
- One natural sub-module, `pc_src_sel`: the combinational 4:1 WIDTH-bit selector, reusable for other datapath muxes.
- The PC register and the `Misaligned` flag stay in the top level.

## Test plan

- Select sweep, `PCWrite`=0. Apply each step and check `Data_out` after 5 time units:
  - sel=0, Exc=5, others 0 → 5.
  - sel=1, EPC=5, others 0 → 5.
  - sel=2, Exc=5, ALU=5, others 0 → 5.
  - sel=3, SL2=5, others 0 → 5.
  - In every step, `PC_Out` is unchanged.
- Isolation: each data input in turn gets a distinct value (e.g. 32'hA0, 32'hB4, 32'hC8, 32'hDC) while the select rotates 0–3 → `Data_out` always equals only the selected input.
- Reset:
  - Assert `reset` with `PCWrite`=1 and sel=2, ALU=32'h40 → `PC_Out`=0 after the edge, while `Data_out`=32'h40 throughout.
  - Deassert `reset` → the next edge loads 32'h40.
- Write enable:
  - sel=3, SL2=32'h0040_0100, `PCWrite` pulsed for one cycle → `PC_Out`=32'h0040_0100.
  - Then change SL2 to 32'h0 with `PCWrite`=0 → `PC_Out` holds 32'h0040_0100.
- Misalignment: sel=2, ALU=32'h0000_0006 → `Misaligned`=1; ALU=32'h0000_0008 → `Misaligned`=0. In both cases `Data_out` equals ALU unchanged.
- Full-width values: sel=1, EPC=32'hFFFF_FFFC with `PCWrite`=1 → `Data_out` and, one edge later, `PC_Out` equal 32'hFFFF_FFFC with no truncation.
